// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, FSM states and decode helpers for multicycle_core
package core_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_HALT   = 7'b1111111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALU operation encodings: {IR[30], IR[25], funct3}
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b10101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_MUL  = 5'b01000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_t;

    // Raw immediates; the core sign-extends them to XLEN.
    function automatic logic [11:0] imm_i_raw(input logic [31:0] ir);
        return ir[31:20];
    endfunction

    function automatic logic [11:0] imm_s_raw(input logic [31:0] ir);
        return {ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [12:0] imm_b_raw(input logic [31:0] ir);
        return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    // True for the ALU codes the datapath implements.
    function automatic logic alu_op_legal(input logic [4:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - combinational ALU for multicycle_core
// Ports:
//   opc  in  5     ALU operation (core_pkg ALU_* encodings)
//   op1  in  XLEN  first operand
//   op2  in  XLEN  second operand; low $clog2(XLEN) bits are the shift amount
//   res  out XLEN  result (MUL returns the low XLEN bits)
module core_alu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      opc,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] res
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = op2[SH_W-1:0];

    always_comb begin
        res = '0;
        case (opc)
            ALU_ADD:  res = op1 + op2;
            ALU_SUB:  res = op1 - op2;
            ALU_SLL:  res = op1 << shamt;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  res = op1 ^ op2;
            ALU_SRL:  res = op1 >> shamt;
            ALU_SRA:  res = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   res = op1 | op2;
            ALU_AND:  res = op1 & op2;
            ALU_MUL:  res = op1 * op2;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV-style core with handshaked instruction/data memories
// Ports:
//   clock, reset           core clock; synchronous active-high reset
//   imem_req/addr          fetch request and word address (= PC)
//   imem_ack/rdata         fetch completion and instruction word
//   dmem_req/we/addr/wdata data request, store enable, word address, store data
//   dmem_ack/rdata         data completion and load data
//   halted, illegal        core stopped; stop caused by an illegal instruction
//   instret                retired-instruction counter (wraps at 2^32)
module multicycle_core
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 5,
    parameter int DADDR_W = 8,
    parameter int NREGS   = 32
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               halted,
    output logic               illegal,
    output logic [31:0]        instret
);

    localparam int              RI_W    = $clog2(NREGS);
    localparam logic [5:0]      NREGS_L = 6'(NREGS);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [XLEN-1:0]   a, b, r, mdr;
    logic [XLEN-1:0]   regs [NREGS];

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    // Sign-extended immediates
    logic [11:0]     imm_i12, imm_s12;
    logic [12:0]     imm_b13;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    assign imm_i12 = imm_i_raw(ir);
    assign imm_s12 = imm_s_raw(ir);
    assign imm_b13 = imm_b_raw(ir);
    assign imm_i   = {{(XLEN-12){imm_i12[11]}}, imm_i12};
    assign imm_s   = {{(XLEN-12){imm_s12[11]}}, imm_s12};
    assign imm_b   = {{(XLEN-13){imm_b13[12]}}, imm_b13};

    // Branch offset in words; the add wraps modulo 2^PC_W
    logic [PC_W-1:0] br_off;
    assign br_off = imm_b[PC_W+1:2];

    // Decode: ALU op, operand select and legality
    logic [4:0] alu_op;
    logic       known_op, op_ok, use_rd, use_rs1, use_rs2, reg_bad;

    always_comb begin
        alu_op   = ALU_ADD;
        known_op = 1'b0;
        op_ok    = 1'b1;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_R: begin
                alu_op   = {ir[30], ir[25], f3};
                known_op = 1'b1;
                op_ok    = alu_op_legal({ir[30], ir[25], f3});
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_I: begin
                alu_op   = {ir[30] & (f3 == 3'b101), 1'b0, f3};
                known_op = 1'b1;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
            end
            OPC_LOAD: begin
                known_op = 1'b1;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
            end
            OPC_STORE: begin
                known_op = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                known_op = 1'b1;
                op_ok    = (f3 == F3_BEQ) || (f3 == F3_BNE);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            default: ;
        endcase
    end

    // Only the register fields the format actually uses are range-checked
    assign reg_bad = (use_rd  && ({1'b0, rd}  >= NREGS_L)) ||
                     (use_rs1 && ({1'b0, rs1} >= NREGS_L)) ||
                     (use_rs2 && ({1'b0, rs2} >= NREGS_L));

    // ALU
    logic [XLEN-1:0] op2_sel, alu_res;
    always_comb begin
        op2_sel = b;
        case (opcode)
            OPC_I, OPC_LOAD: op2_sel = imm_i;
            OPC_STORE:       op2_sel = imm_s;
            default:         op2_sel = b;
        endcase
    end

    core_alu #(.XLEN(XLEN)) u_alu (
        .opc (alu_op),
        .op1 (a),
        .op2 (op2_sel),
        .res (alu_res)
    );

    logic br_taken;
    assign br_taken = (f3 == F3_BNE) ? (a != b) : (a == b);

    // Memory-side outputs come straight from stable registers during MEM
    assign imem_addr  = pc;
    assign dmem_addr  = r[DADDR_W+1:2];
    assign dmem_wdata = b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            r        <= '0;
            mdr      <= '0;
            instret  <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // After reset the request is raised here; every later
                    // entry into FETCH arrives with imem_req already set.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a <= regs[rs1[RI_W-1:0]];
                    b <= regs[rs2[RI_W-1:0]];
                    if (opcode == OPC_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALTED;
                    end else if (!known_op || !op_ok || reg_bad) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= ST_HALTED;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r <= alu_res;
                    if (opcode == OPC_BRANCH) begin
                        pc       <= br_taken ? pc + br_off : pc + PC_ONE;
                        instret  <= instret + 32'd1;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (opcode == OPC_STORE);
                        state    <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc       <= pc + PC_ONE;
                            instret  <= instret + 32'd1;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (rd != 5'd0) begin
                        regs[rd[RI_W-1:0]] <= (opcode == OPC_LOAD) ? mdr : r;
                    end
                    pc       <= pc + PC_ONE;
                    instret  <= instret + 32'd1;
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALTED: ;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - scoreboard testbench for multicycle_core
module tb_multicycle_core;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [31:0] HALT = 32'h0000007F;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata = '0;
    logic        halted, illegal;
    logic [31:0] instret;

    logic        reset2 = 1'b1;
    logic        imem_req2, imem_ack2 = 1'b0;
    logic [4:0]  imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        dmem_req2, dmem_we2;
    logic        dmem_ack2 = 1'b0;
    logic [7:0]  dmem_addr2;
    logic [31:0] dmem_wdata2, dmem_rdata2 = '0;
    logic        halted2, illegal2;
    logic [31:0] instret2;

    multicycle_core dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .illegal(illegal), .instret(instret)
    );

    multicycle_core #(.NREGS(16)) dut16 (
        .clock(clock), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2),
        .halted(halted2), .illegal(illegal2), .instret(instret2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [11:0] im; logic [4:0] s1, d; logic [2:0] f;
        im = 12'(imm); s1 = 5'(rs1); d = 5'(rd); f = 3'(f3);
        return {im, s1, f, d, op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [6:0] f; logic [4:0] s1, s2, d; logic [2:0] t;
        f = 7'(f7); s2 = 5'(rs2); s1 = 5'(rs1); t = 3'(f3); d = 5'(rd);
        return {f, s2, s1, t, d, OP_R};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im; logic [4:0] s1, s2;
        im = 12'(imm); s1 = 5'(rs1); s2 = 5'(rs2);
        return {im[11:5], s2, s1, 3'b010, im[4:0], OP_ST};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im; logic [4:0] s1, s2; logic [2:0] f;
        im = 13'(imm); s1 = 5'(rs1); s2 = 5'(rs2); f = 3'(f3);
        return {im[12], im[10:5], s2, s1, f, im[4:1], im[11], OP_BR};
    endfunction

    // Memories, scoreboards and monitors
    typedef struct { logic [7:0] addr; logic [31:0] data; } st_t;
    st_t         exp_q[$];
    st_t         e;
    int          fetch_exp[$];
    bit          fetch_chk = 0;
    logic [31:0] imem [32];
    logic [31:0] dmem [64];
    int          imem_ws = 0, dmem_ws = 0;
    bit          dmem_block = 0;
    int          i_cnt = 0, d_cnt = 0, d_hold = 0, stable_err = 0;
    logic [7:0]  d_addr_last = '0;
    int          txn_addr[$], txn_hold[$], txn_we[$];
    int          cyc = 0;
    int          ret_cyc[$];
    int          halted_cyc = -1;
    logic [31:0] last_instret = '0;
    logic        last_halted = 1'b0;
    logic [31:0] insn16;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (imem_req) begin
            if (i_cnt == imem_ws) begin
                imem_ack   = 1'b1;
                imem_rdata = imem[imem_addr];
                i_cnt      = 0;
                if (fetch_chk)
                    chk("fetch_addr", {27'b0, imem_addr},
                        (fetch_exp.size() > 0) ? fetch_exp.pop_front() : 32'hFFFFFFFF);
            end else begin
                imem_ack = 1'b0;
                i_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            i_cnt    = 0;
        end
    end

    always @(negedge clock) begin
        if (dmem_req) begin
            d_hold++;
            if (d_hold > 1 && dmem_addr != d_addr_last) stable_err++;
            d_addr_last = dmem_addr;
            if (!dmem_block && d_cnt == dmem_ws) begin
                dmem_ack = 1'b1;
                txn_addr.push_back(int'(dmem_addr));
                txn_hold.push_back(d_hold);
                txn_we.push_back(int'(dmem_we));
                if (dmem_we) begin
                    dmem[dmem_addr[5:0]] = dmem_wdata;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("store_addr", {24'b0, dmem_addr}, {24'b0, e.addr});
                        chk("store_data", dmem_wdata, e.data);
                    end else begin
                        chk("store_unexpected", {24'b0, dmem_addr}, 32'hFFFFFFFF);
                    end
                end else begin
                    dmem_rdata = dmem[dmem_addr[5:0]];
                end
                d_cnt  = 0;
                d_hold = 0;
            end else begin
                dmem_ack = 1'b0;
                d_cnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            d_cnt    = 0;
            d_hold   = 0;
        end
    end

    always @(negedge clock) begin
        imem_ack2   = imem_req2;
        imem_rdata2 = insn16;
    end

    always @(negedge clock) begin
        if (reset) begin
            last_instret = '0;
        end else if (instret != last_instret) begin
            ret_cyc.push_back(cyc);
            last_instret = instret;
        end
        if (!reset && halted && !last_halted) halted_cyc = cyc;
        last_halted = halted;
    end

    function automatic int rdiff(input int i, input int j);
        if (ret_cyc.size() <= i || ret_cyc.size() <= j) return -1;
        return ret_cyc[i] - ret_cyc[j];
    endfunction

    function automatic int halt_lat();
        if (ret_cyc.size() == 0 || halted_cyc < 0) return -1;
        return halted_cyc - ret_cyc[ret_cyc.size()-1];
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) imem[i] = HALT;
    endtask

    task automatic do_reset(input bit check_state);
        @(negedge clock);
        reset = 1'b1;
        ret_cyc.delete();
        txn_addr.delete(); txn_hold.delete(); txn_we.delete();
        halted_cyc = -1;
        stable_err = 0;
        repeat (2) @(negedge clock);
        if (check_state) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_dmem_req", dmem_req, 0);
            chk("rst_dmem_we", dmem_we, 0);
            chk("rst_halted", halted, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_instret", instret, 0);
            chk("rst_pc", imem_addr, 0);
        end
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, halted, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic count_req(input string tag, input int ncyc);
        int hits;
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (imem_req || dmem_req) hits++;
        end
        chk(tag, hits, 0);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] insn);
        clear_imem();
        imem[0] = insn;
        do_reset(0);
        wait_halt({tag, "_halt"}, 50);
        chk({tag, "_illegal"}, illegal, 1);
        chk({tag, "_instret"}, instret, 0);
    endtask

    initial begin
        int n;
        insn16 = enc_i(1, 0, 0, 20, OP_I);

        // ALU ops, MUL/SUB, zero-wait, ending in HALT
        imem_ws = 0; dmem_ws = 0;
        clear_imem();
        imem[0] = enc_i(-5, 0, 0, 1, OP_I);
        imem[1] = enc_i(12'h401, 1, 5, 2, OP_I);
        imem[2] = enc_s(0, 2, 0);
        exp_q.push_back('{8'd0, 32'hFFFFFFFD});
        imem[3] = enc_i(7, 0, 0, 1, OP_I);
        imem[4] = enc_i(6, 0, 0, 2, OP_I);
        imem[5] = enc_r(1, 2, 1, 0, 3);
        imem[6] = enc_r(32, 2, 1, 0, 4);
        imem[7] = enc_s(4, 3, 0);
        exp_q.push_back('{8'd1, 32'd42});
        imem[8] = enc_s(12, 4, 0);
        exp_q.push_back('{8'd3, 32'd1});
        do_reset(1);
        reset2 = 1'b0;
        @(negedge clock);
        chk("first_fetch_req", imem_req, 1);
        chk("first_fetch_addr", imem_addr, 0);
        wait_halt("A_halt", 300);
        chk("A_alu_latency", rdiff(1, 0), 4);
        chk("A_store_latency", rdiff(2, 1), 4);
        chk("A_instret", instret, 9);
        chk("A_illegal", illegal, 0);
        chk("A_halt_latency", halt_lat(), 2);
        chk("A_stores_done", exp_q.size(), 0);
        count_req("A_no_req_after_halt", 6);
        chk("A_pc_frozen", imem_addr, 9);
        chk("A_instret_frozen", instret, 9);
        chk("n16_halted", halted2, 1);
        chk("n16_illegal", illegal2, 1);
        chk("n16_instret", instret2, 0);
        chk("n16_no_req", imem_req2, 0);

        // Stores/loads with three wait states on dmem
        dmem_ws = 3;
        clear_imem();
        imem[0] = enc_i(7, 0, 0, 1, OP_I);
        imem[1] = enc_i(6, 0, 0, 2, OP_I);
        imem[2] = enc_r(1, 2, 1, 0, 3);
        imem[3] = enc_s(8, 3, 0);
        exp_q.push_back('{8'd2, 32'd42});
        imem[4] = enc_i(8, 0, 2, 5, OP_LD);
        imem[5] = enc_s(16, 5, 0);
        exp_q.push_back('{8'd4, 32'd42});
        do_reset(0);
        wait_halt("C_halt", 300);
        chk("C_txn_count", txn_addr.size(), 3);
        if (txn_addr.size() >= 2) begin
            chk("C_sw_addr", txn_addr[0], 2);
            chk("C_sw_hold", txn_hold[0], 4);
            chk("C_sw_we", txn_we[0], 1);
            chk("C_lw_addr", txn_addr[1], 2);
            chk("C_lw_hold", txn_hold[1], 4);
            chk("C_lw_we", txn_we[1], 0);
        end
        chk("C_store_latency", rdiff(3, 2), 7);
        chk("C_load_latency", rdiff(4, 3), 8);
        chk("C_addr_stable", stable_err, 0);
        chk("C_stores_done", exp_q.size(), 0);
        chk("C_instret", instret, 6);

        // Branches: not-taken BEQ, jump to 31, BNE wrapping to 1; one imem wait state
        imem_ws = 1; dmem_ws = 0;
        clear_imem();
        imem[0]  = enc_i(1, 0, 0, 1, OP_I);
        imem[1]  = enc_b(12, 1, 2, 0);
        imem[2]  = enc_i(1, 0, 0, 2, OP_I);
        imem[3]  = enc_b(112, 0, 0, 0);
        imem[31] = enc_b(8, 0, 1, 1);
        fetch_exp = '{0, 1, 2, 3, 31, 1, 4};
        fetch_chk = 1;
        do_reset(0);
        wait_halt("D_halt", 300);
        fetch_chk = 0;
        chk("D_fetches_done", fetch_exp.size(), 0);
        chk("D_instret", instret, 6);
        chk("D_beq_nt_latency", rdiff(1, 0), 4);
        chk("D_bne_latency", rdiff(4, 3), 4);
        chk("D_pc_frozen", imem_addr, 4);
        chk("D_illegal", illegal, 0);

        // Illegal opcode trap with imem wait states
        imem_ws = 2;
        clear_imem();
        imem[0] = enc_i(1, 0, 0, 1, OP_I);
        imem[1] = 32'h0000000F;
        do_reset(0);
        wait_halt("E_halt", 200);
        chk("E_illegal", illegal, 1);
        chk("E_instret", instret, 1);
        chk("E_halt_latency", halt_lat(), 4);
        count_req("E_no_req_after_trap", 10);
        chk("E_pc_frozen", imem_addr, 1);

        imem_ws = 0;
        run_illegal("E_rtype_code", enc_r(1, 2, 1, 1, 3));
        run_illegal("E_branch_f3", enc_b(8, 0, 0, 4));

        // Reset while a load waits for an ack that never comes
        clear_imem();
        imem[0] = enc_i(5, 0, 0, 1, OP_I);
        imem[1] = enc_i(20, 0, 2, 2, OP_LD);
        dmem_block = 1;
        do_reset(0);
        n = 0;
        while (!dmem_req && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("F_load_req", dmem_req, 1);
        chk("F_load_addr", dmem_addr, 5);
        chk("F_load_we", dmem_we, 0);
        chk("F_instret_pre", instret, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("F_rst_dmem_req", dmem_req, 0);
        chk("F_rst_pc", imem_addr, 0);
        chk("F_rst_instret", instret, 0);
        chk("F_rst_halted", halted, 0);
        reset = 1'b0;
        dmem_block = 0;
        @(negedge clock);
        chk("F_refetch_req", imem_req, 1);
        chk("F_refetch_addr", imem_addr, 0);
        repeat (4) @(negedge clock);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle processor. It replaces combinational instruction and data memory access with valid/ack handshakes, so it tolerates wait-stated memories. It adds conditional branches, sign-extended immediates, an illegal-opcode trap and a retired-instruction counter. It sits between the board PLL clock domain and external instruction and data memories.

## Interface
- `XLEN`, 32: datapath and register width, ≥32.
- `PC_W`, 5: word-indexed PC width.
- `DADDR_W`, 8: word-indexed data address width.
- `NREGS`, 32: register count, 16 or 32.
- `clock`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  `PC_W`  fetch word address (= PC).
- `imem_ack`  in  1  fetch done; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `dmem_req`  out  1  data request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  `DADDR_W`  equals `alu_res[DADDR_W+1:2]`.
- `dmem_wdata`  out  `XLEN`  store data (rs2).
- `dmem_ack`  in  1  data done; `dmem_rdata` valid this cycle.
- `dmem_rdata`  in  `XLEN`  load data.
- `halted`  out  1  core stopped (halt or trap).
- `illegal`  out  1  stop was caused by an illegal instruction.
- `instret`  out  32  retired-instruction count.

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- **FETCH:** assert `imem_req`. When `imem_ack` is high, latch `imem_rdata` into IR and go to DECODE.
- **DECODE:** read rs1 = IR[19:15] and rs2 = IR[24:20] into A and B. Transitions:
  - opcode 1111111 → HALTED.
  - unknown opcode, or register index ≥ `NREGS` → HALTED with `illegal` = 1.
  - otherwise → EXEC.
- **Opcodes:** 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch (BEQ funct3 000, BNE 001; any other funct3 is illegal).
- **ALU op (5 bits):**
  - R-type: {IR[30], IR[25], funct3}.
  - I-type: {IR[30] & (funct3 == 101), 0, funct3}.
  - load/store: ADD.
  - Encodings: ADD 00000, SUB 10000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 10101, OR 00110, AND 00111, MUL 01000 (low `XLEN` bits).
  - Any other R-type code is illegal, detected in DECODE.
- **Immediates:** sign-extended to `XLEN` (I: IR[31:20]; S: {IR[31:25], IR[11:7]}; B: standard RISC-V B-format). Shift amount is `op2[$clog2(XLEN)-1:0]`.
- **EXEC:** latch the ALU result into R.
  - Branch: if taken, PC ← PC + `imm_b[PC_W+1:2]` (two's complement, wraps modulo 2^`PC_W`); else PC+1. Then go to FETCH and retire.
  - Load/store → MEM. ALU ops → WB.
- **MEM:** assert `dmem_req`, with `dmem_we` for stores. On `dmem_ack`: a load latches `dmem_rdata` and goes to WB; a store sets PC+1, goes to FETCH and retires.
- **WB:** write R (or load data) to rd = IR[11:7]. Writes to x0 are discarded and x0 always reads 0. PC ← PC+1, go to FETCH, retire.
- **Retire:** `instret` += 1 and wraps at 2^32. HALT does not retire.
- **HALTED:** terminal. No requests; PC, `instret` and registers frozen. Only `reset` leaves it.

## Timing
- Reset (sync) values: PC = 0, state = FETCH, all registers = 0, `instret` = 0, `halted` = 0, `illegal` = 0, `imem_req` = `dmem_req` = `dmem_we` = 0. First fetch request is asserted the cycle after `reset` deasserts.
- Handshake: `req`, address, `we` and `wdata` are held stable until the cycle `ack` is sampled high. `ack` in the same cycle `req` rises completes the transfer. `req` drops the cycle after `ack`. `ack` while `req` is low is ignored.
- Zero-wait latencies: ALU 4 cycles, load 5, store 4, branch 3, halt 2 (FETCH → DECODE → HALTED). Each wait cycle on `ack` adds one.
- `halted` and `illegal` rise on the clock edge entering HALTED.
- Reset mid-transaction abandons the request. Memories must accept `req` dropping without `ack`.

## Structure
- `core_pkg` holds: opcode constants, ALU op encodings, FSM state enum, immediate-extract functions.
- One sub-module, `core_alu`, parametrised by `XLEN`, with ports `opc`, `op1`, `op2`, `res`. The register file is a local array in the core.

## Test plan
- **ALU ops, zero-wait:** ADDI x1,x0,-5 then SRAI x2,x1,1 → x2 = 0xFFFFFFFD; each instruction 4 cycles; `instret` = 2.
- **MUL:** x1 = 7, x2 = 6, MUL x3,x1,x2 → x3 = 42. SUB x4,x1,x2 → x4 = 1.
- **Memory with 3 wait states on dmem:** SW x3,8(x0) then LW x5,8(x0) → `dmem_addr` = 2 held for 4 cycles per access, x5 = 42, load takes 8 cycles.
- **Branch wrap:** PC = 31, BNE taken with offset +8 → next `imem_addr` = 1. A not-taken BEQ advances PC by 1.
- **Illegal trap:** opcode 0001111 → `halted` = 1 and `illegal` = 1 after DECODE; no further `imem_req`. Same check with `NREGS` = 16 and rd = x20.
- **Reset mid-load and HALT:** reset asserted during MEM with `ack` withheld → next cycle `dmem_req` = 0, PC = 0, `instret` = 0. Opcode 1111111 → `halted` = 1, `illegal` = 0, PC frozen.
